// File: rtl/fp_pkg.sv
// Shared binary32 constants, the unpacked-operand record and its unpack helper.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  // Subnormals are flushed: exponent 0 always yields a signed zero.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.mant    = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    u.is_zero = (x[30:23] == 8'd0);
    u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    return u;
  endfunction
endpackage

// File: rtl/fp_normalize.sv
// Leading-zero count and left shift bringing the leading one to bit 26.
module fp_normalize (
  input  logic [26:0] val,
  output logic [26:0] shifted,
  output logic [4:0]  lzc
);
  logic found;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (val[i]) found = 1'b1;
        else        lzc   = lzc + 5'd1;
      end
    end
  end

  assign shifted = val << lzc;
endmodule

// File: rtl/floating_point_adder.sv
// Single-cycle binary32 adder: combinational datapath, registered result, RNE rounding, FTZ.
module floating_point_adder
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  fp_unpacked_t ua, ub;
  logic        swap, eff_sub, l_sign;
  logic [7:0]  l_exp, s_exp, diff;
  logic [23:0] l_mant, s_mant;
  logic [49:0] wide;
  logic [26:0] large_ext, small_ext, pre, norm;
  logic [27:0] raw;
  logic [4:0]  lzc;
  logic signed [9:0] exp_pre, exp_n, exp_r;
  logic        round_up;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic [31:0] sum_c;

  assign ua = fp_unpack(a);
  assign ub = fp_unpack(b);

  // Magnitude order on {exp, mant}; ties keep a as large, which is harmless.
  assign swap   = {ub.exp, ub.mant} > {ua.exp, ua.mant};
  assign l_sign = swap ? ub.sign : ua.sign;
  assign l_exp  = swap ? ub.exp  : ua.exp;
  assign l_mant = swap ? ub.mant : ua.mant;
  assign s_exp  = swap ? ua.exp  : ub.exp;
  assign s_mant = swap ? ua.mant : ub.mant;
  assign eff_sub = ua.sign ^ ub.sign;
  assign diff    = l_exp - s_exp;

  // 27-bit working format: {mant[23:0], guard, round, sticky}.
  assign wide      = {s_mant, 26'd0} >> diff;
  assign small_ext = (diff >= 8'd26) ? {26'd0, |s_mant} : {wide[49:24], |wide[23:0]};
  assign large_ext = {l_mant, 3'b000};
  assign raw       = eff_sub ? ({1'b0, large_ext} - {1'b0, small_ext})
                             : ({1'b0, large_ext} + {1'b0, small_ext});

  always_comb begin
    if (raw[27]) begin
      pre     = {raw[27:2], raw[1] | raw[0]};
      exp_pre = $signed({2'b00, l_exp}) + 10'sd1;
    end else begin
      pre     = raw[26:0];
      exp_pre = $signed({2'b00, l_exp});
    end
  end

  fp_normalize u_norm (.val(pre), .shifted(norm), .lzc(lzc));

  always_comb begin
    exp_n    = exp_pre - $signed({5'd0, lzc});
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      exp_r  = exp_n + 10'sd1;
      frac_r = mant_r[23:1];
    end else begin
      exp_r  = exp_n;
      frac_r = mant_r[22:0];
    end
  end

  always_comb begin
    sum_c = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && eff_sub))
      sum_c = QNAN;
    else if (ua.is_inf)
      sum_c = ua.sign ? NEG_INF : POS_INF;
    else if (ub.is_inf)
      sum_c = ub.sign ? NEG_INF : POS_INF;
    else if (ua.is_zero && ub.is_zero)
      sum_c = {ua.sign & ub.sign, 31'd0};
    else if (ua.is_zero)
      sum_c = b;
    else if (ub.is_zero)
      sum_c = a;
    else if (pre == 27'd0)
      sum_c = 32'd0;
    else if (exp_r >= 10'sd255)
      sum_c = l_sign ? NEG_INF : POS_INF;
    else if (exp_r <= 10'sd0)
      sum_c = {l_sign, 31'd0};
    else
      sum_c = {l_sign, exp_r[7:0], frac_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result <= '0;
    else        result <= sum_c;
  end
endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder with an async-reset sequence.
module tb_floating_point_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  floating_point_adder dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .result(result));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  task automatic add(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e, input string n);
    vec_t v;
    v.a = x; v.b = y; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    add(32'h3F000000, 32'h3F000000, 32'h3F800000, "half_plus_half");
    add(32'h3F000000, 32'hBEE00000, 32'h3D800000, "sub_cancel");
    add(32'hBEE00000, 32'h3F000000, 32'h3D800000, "sub_cancel_swapped");
    add(32'hBF400000, 32'hBF400000, 32'hBFC00000, "neg_add");
    add(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even");
    add(32'h3F800000, 32'h33C00000, 32'h3F800001, "above_tie");
    add(32'h3F800000, 32'hB3000000, 32'h3F800000, "sub_tie_round_carry");
    add(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_pos");
    add(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, "overflow_neg");
    add(32'h40400000, 32'hC0400000, 32'h00000000, "exact_zero");
    add(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    add(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
    add(32'h3F800000, 32'h7F800001, 32'h7FC00000, "snan_in");
    add(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_plus_fin");
    add(32'hFF800000, 32'hFF800000, 32'hFF800000, "ninf_plus_ninf");
    add(32'h80000000, 32'h80000000, 32'h80000000, "negz_negz");
    add(32'h00000000, 32'h80000000, 32'h00000000, "posz_negz");
    add(32'h00000000, 32'h40490FDB, 32'h40490FDB, "zero_pass");
    add(32'h00000001, 32'h3F800000, 32'h3F800000, "subnorm_flush");
    add(32'h80000001, 32'h80000001, 32'h80000000, "subnorm_neg_zeros");
    add(32'h3F800000, 32'h40000000, 32'h40400000, "one_plus_two");
    add(32'h3F800000, 32'h00800000, 32'h3F800000, "huge_diff_sticky");
    add(32'h80800001, 32'h00800000, 32'h80000000, "underflow_ftz");

    rst_n = 1'b0; a = '0; b = '0;
    #2;
    check("reset_state", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      check(vecs[i].name, result, vecs[i].exp);
      @(negedge clk);
    end

    // Back-to-back throughput: new operands every cycle.
    a = 32'h3F800000; b = 32'h3F800000;
    @(posedge clk); #1;
    check("b2b_first", result, 32'h40000000);
    a = 32'h40400000; b = 32'hC0400000;
    @(posedge clk); #1;
    check("b2b_second", result, 32'h00000000);

    // Async reset mid-stream: clear without an edge, hold, then resume.
    a = 32'h3F000000; b = 32'h3F000000;
    @(posedge clk); #1;
    check("pre_reset", result, 32'h3F800000);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", result, 32'h0);
    a = 32'hBF400000; b = 32'hBF400000;
    @(posedge clk); #1;
    check("held_in_reset", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_stale", result, 32'h0);
    @(posedge clk); #1;
    check("resume_after_reset", result, 32'hBFC00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/floating_point_adder.md
FLOATING_POINT_ADDER -- requirements
Module: floating_point_adder

Interface
REQ-001 SHALL have no parameters; format fixed to IEEE-754 binary32 (1 sign, 8 exponent, 23 fraction bits).
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: a  input  32  first operand, binary32.
REQ-005 SHALL provide port: b  input  32  second operand, binary32.
REQ-006 SHALL provide port: result  output  32  registered binary32 sum a+b.

Function
REQ-007 SHALL sample a and b on each rising clk edge and present their sum on result after that same edge; latency 1 cycle, throughput 1 per cycle, no handshake.
REQ-008 SHALL compute the datapath combinationally: unpack, compare, align, add/subtract, normalize, round, pack. Only result is registered.
REQ-009 SHALL restore the hidden 1 for normal operands (exponent 1..254).
REQ-010 SHALL treat a subnormal input (exponent 0, fraction nonzero) as signed zero (flush-to-zero).
REQ-011 SHALL order operands by magnitude (exponent, then mantissa) and shift the smaller right by the exponent difference. Shifted-out bits SHALL collect into guard, round and sticky bits. A difference of 26 or more SHALL leave only sticky.
REQ-012 SHALL add mantissas when signs match. Otherwise it SHALL subtract the smaller from the larger, and the result sign SHALL be the sign of the larger magnitude.
REQ-013 SHALL handle normalization as follows:
- On carry-out: shift right 1 and increment the exponent.
- On cancellation: shift left by the leading-zero count and decrement the exponent.
REQ-014 SHALL round to nearest, ties to even, using guard/round/sticky. A rounding carry SHALL renormalize (exponent +1).
REQ-015 SHALL return a correctly signed infinity (0x7F800000 / 0xFF800000) when the final exponent reaches 255 or more.
REQ-016 SHALL flush to signed zero (fraction 0) when the final exponent falls to 0 or below.
REQ-017 SHALL return +0 (0x00000000) for an exact-zero difference x+(-x).
REQ-018 SHALL handle signed zeros: (-0)+(-0) -> 0x80000000; (+0)+(-0) -> 0x00000000.
REQ-019 SHALL return canonical quiet NaN 0x7FC00000 when either input is NaN, or for (+inf)+(-inf).
REQ-020 SHALL return that infinity for inf plus a finite value, or for inf plus an infinity of the same sign.
REQ-021 SHALL pass a zero (after flush) plus a finite nonzero operand through as the nonzero operand unchanged.
REQ-022 SHALL give an identical result for (a,b) and (b,a).

Reset
REQ-023 SHALL force result to 0x00000000 immediately on rst_n low, independent of clk.
REQ-024 SHALL hold result at 0x00000000 while rst_n is low, and resume sampling at the first rising clk after rst_n goes high.
REQ-025 SHALL discard any operation in flight when reset is asserted mid-operation; no stale value SHALL appear after release.

Structure
REQ-026 SHALL define these in a shared package fp_pkg:
- bias 127, EXP_W=8, FRAC_W=23
- QNAN=0x7FC00000, POS_INF, NEG_INF
- an unpacked-operand struct (sign, exponent, 24-bit mantissa, is_zero, is_inf, is_nan)
REQ-027 SHALL put the leading-zero count and left shift in one sub-module, fp_normalize. Everything else SHALL stay in floating_point_adder.
REQ-028 SHALL be synthesizable, with a single always-block register for result and no latches.

Verification
REQ-029 SHALL verify these directed scenarios; each result is checked one cycle after the inputs are applied:
- 0x3F000000 + 0x3F000000 (0.5+0.5) -> 0x3F800000
- 0x3F000000 + 0xBEE00000 (0.5-0.4375) -> 0x3D800000; 0xBEE00000 + 0x3F000000 -> 0x3D800000
- 0xBF400000 + 0xBF400000 (-0.75-0.75) -> 0xBFC00000
- 0x3F800000 + 0x33800000 (1 + 2^-24, tie) -> 0x3F800000
- 0x3F800000 + 0x33C00000 (above tie) -> 0x3F800001
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000
- 0x40400000 + 0xC0400000 -> 0x00000000
- 0x7F800000 + 0xFF800000 -> 0x7FC00000
- rst_n pulsed low mid-stream -> result 0x00000000 without a clk edge; correct sums resume one cycle after release
